// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter
//   Round-robin arbiter that shares one datapath resource among three
//   requesters (A, B, C). It drives the 3:1 bus-mux select, pulses res_start
//   on the first cycle of each grant, and holds the grant until res_done.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   req[2:0]     request lines, bit0=A, bit1=B, bit2=C
//   res_done     resource completion pulse
//   gnt[2:0]     one-hot registered grant, same bit order as req
//   sel[1:0]     mux select: 00=A, 10=B, 01=C
//   res_start    one-cycle pulse on the first cycle of each grant
//   busy         high while a grant is active
//   timeout_err  sticky timeout flag; constant 0 unless ARB_TIMEOUT_EN
//
// Build option
//   ARB_TIMEOUT_EN : if defined, a grant held for TIMEOUT cycles without
//                    res_done is force-released and timeout_err is set.
module mux3_rr_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       res_done,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       res_start,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;      // last-served requester index: 0=A, 1=B, 2=C
    logic [2:0] gnt_d;
    logic [1:0] sel_d;
    logic       res_start_d;
    logic       busy_d;
    logic       release_grant;     // current grant ends this cycle

    // First set bit scanning from (p+1) mod 3. Iterating the furthest
    // candidate first lets the nearest one overwrite it.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] w;
        w = p;
        for (int k = 3; k >= 1; k--) begin
            int i;
            i = (int'(p) + k) % 3;
            if (r[i]) w = 2'(i);
        end
        return w;
    endfunction

    // Datapath mux encoding is not the plain index: B and C are swapped bits.
    function automatic logic [1:0] sel_code(input logic [1:0] idx);
        case (idx)
            2'd1:    return 2'b10;
            2'd2:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             tmo_hit;
    logic             timeout_err_q;

    // The counter would reach TIMEOUT at this edge: release now.
    assign tmo_hit = (state_q == BUSY) && !res_done &&
                     (cnt_q == CNT_W'(TIMEOUT - 1));
    assign release_grant = res_done || tmo_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (res_start_d || state_d != BUSY)
                cnt_q <= '0;
            else if (state_q == BUSY && !res_done)
                cnt_q <= cnt_q + 1'b1;
            if (tmo_hit)
                timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_cfg;
    assign unused_cfg    = ^{TIMEOUT, CNT_W};
    assign release_grant = res_done;
    assign timeout_err   = 1'b0;
`endif

    // Next-state / next-output logic
    always_comb begin
        logic [1:0] win;
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt;
        sel_d       = sel;
        res_start_d = 1'b0;
        busy_d      = busy;
        win         = rr_pick(req, ptr_q);

        case (state_q)
            IDLE: begin
                if (req != 3'b000) begin
                    state_d     = BUSY;
                    gnt_d       = 3'b001 << win;
                    sel_d       = sel_code(win);
                    res_start_d = 1'b1;
                    busy_d      = 1'b1;
                    ptr_d       = win;
                end
            end
            BUSY: begin
                if (release_grant) begin
                    if (req != 3'b000) begin
                        // Back-to-back grant, no idle gap.
                        gnt_d       = 3'b001 << win;
                        sel_d       = sel_code(win);
                        res_start_d = 1'b1;
                        ptr_d       = win;
                    end else begin
                        // sel keeps the last code to avoid mux churn.
                        state_d = IDLE;
                        gnt_d   = 3'b000;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd2;   // C last served, so A wins first
            gnt       <= 3'b000;
            sel       <= 2'b00;
            res_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt       <= gnt_d;
            sel       <= sel_d;
            res_start <= res_start_d;
            busy      <= busy_d;
        end
    end

endmodule
